// File: rtl/udp_tx_data.sv
// udp_tx_data: frames one 32-bit word into an 8-byte UDP payload and streams it to the stack.
//   Payload: HDR[15:8] HDR[7:0] data[31:24] .. data[7:0] seq[15:8] seq[7:0].
//   udp_tx_clk / reset           clock, asynchronous active-high reset
//   data_in / data_in_valid      word to send and its strobe
//   data_in_ready                high only while idle
//   app_tx_data_request          request to the stack, held until ack or timeout
//   app_tx_ack                   grant from the stack
//   app_tx_data_valid / _data    payload byte stream, 8 consecutive cycles
//   app_tx_data_length           constant 8
//   tx_drop                      pulse: word offered while busy
//   tx_timeout                   pulse: request abandoned
module udp_tx_data #(
  parameter logic [15:0] HDR        = 16'hA55A,
  parameter int          IFG_CYCLES = 8,
  parameter int          TIMEOUT    = 1024,
  parameter logic [15:0] SEQ_RST    = 16'h0000
) (
  input  logic        udp_tx_clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic        app_tx_data_request,
  input  logic        app_tx_ack,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] app_tx_data_length,
  output logic        tx_drop,
  output logic        tx_timeout
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [15:0]   seq_q, seq_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    byte_q, byte_d;
  logic          ready_q, ready_d, req_q, req_d, valid_q, valid_d;
  logic          drop_q, drop_d, tout_q, tout_d;
  logic [63:0]   frame;
  assign frame = {HDR, word_q, seq_q};
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    ready_d = ready_q;
    req_d   = req_q;
    valid_d = 1'b0;
    byte_d  = 8'h00;
    drop_d  = data_in_valid & ~ready_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: if (data_in_valid) begin
        word_d  = data_in;
        state_d = REQ;
        req_d   = 1'b1;
        ready_d = 1'b0;
        wait_d  = '0;
      end
      // ack takes priority over an expiring wait on the same edge
      REQ: if (app_tx_ack) begin
        req_d   = 1'b0;
        state_d = SEND;
        cnt_d   = 3'd0;
        valid_d = 1'b1;
        byte_d  = HDR[15:8];
      end else if (wait_q == WW'(TIMEOUT - 1)) begin
        req_d   = 1'b0;
        tout_d  = 1'b1;
        state_d = IDLE;
        ready_d = 1'b1;
      end else begin
        wait_d = wait_q + WW'(1);
      end
      SEND: if (cnt_q == 3'd7) begin
        seq_d   = seq_q + 16'd1;
        gap_d   = '0;
        state_d = IFG_CYCLES == 0 ? IDLE : GAP;
        ready_d = IFG_CYCLES == 0;
      end else begin
        cnt_d   = cnt_q + 3'd1;
        valid_d = 1'b1;
        // byte n sits at bit offset (7-n)*8, and 7-n is ~n in three bits
        byte_d  = frame[{~cnt_d, 3'b000} +: 8];
      end
      GAP: if (gap_q == GW'(IFG_CYCLES - 1)) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end else begin
        gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge udp_tx_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      seq_q   <= SEQ_RST;
      cnt_q   <= '0;
      wait_q  <= '0;
      gap_q   <= '0;
      byte_q  <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      tout_q  <= tout_d;
    end
  end
  assign data_in_ready       = ready_q;
  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data         = byte_q;
  assign app_tx_data_length  = 16'd8;
  assign tx_drop             = drop_q;
  assign tx_timeout          = tout_q;
endmodule

// File: tb/tb_udp_tx_data.sv
// tb_udp_tx_data: directed checks of framing, sequencing, gap, drop, timeout and reset.
module tb_udp_tx_data;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [1:0]  div;
  logic        ack;
  logic        rdy[2], req[2], vld[2], drp[2], tout[2];
  logic [7:0]  dat[2];
  logic [15:0] len[2];
  int          n_chk = 0;
  int          n_fail = 0;
  int          k;
  always #5 clk = ~clk;
  udp_tx_data dut (
    .udp_tx_clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(div[0]),
    .data_in_ready(rdy[0]), .app_tx_data_request(req[0]), .app_tx_ack(ack),
    .app_tx_data_valid(vld[0]), .app_tx_data(dat[0]), .app_tx_data_length(len[0]),
    .tx_drop(drp[0]), .tx_timeout(tout[0])
  );
  udp_tx_data #(.SEQ_RST(16'hFFFF)) dut_wrap (
    .udp_tx_clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(div[1]),
    .data_in_ready(rdy[1]), .app_tx_data_request(req[1]), .app_tx_ack(ack),
    .app_tx_data_valid(vld[1]), .app_tx_data(dat[1]), .app_tx_data_length(len[1]),
    .tx_drop(drp[1]), .tx_timeout(tout[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int s, output int n);
    n = 0;
    while (!rdy[s] && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic send(input int s, input logic [31:0] w, input logic [15:0] sq, input int lat,
                      input int drop_at, input int rst_at, input string tag);
    logic [63:0] f;
    f = {16'hA55A, w, sq};
    chk({tag, " ready"}, rdy[s], 1);
    data_in = w;
    div[s] = 1'b1;
    tick();
    div[s] = 1'b0;
    data_in = '0;
    chk({tag, " req"}, req[s], 1);
    chk({tag, " busy"}, rdy[s], 0);
    repeat (lat - 1) begin
      tick();
      chk({tag, " req held"}, req[s], 1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s valid%0d", tag, i), vld[s], 1);
      chk($sformatf("%s byte%0d", tag, i), dat[s], f[63 - 8 * i -: 8]);
      chk($sformatf("%s len%0d", tag, i), len[s], 8);
      if (i == 0) chk({tag, " req drop"}, req[s], 0);
      if (drop_at >= 0 && i == drop_at + 1) begin
        chk({tag, " drop pulse"}, drp[s], 1);
        div[s] = 1'b0;
      end
      if (drop_at >= 0 && i == drop_at + 2) chk({tag, " drop end"}, drp[s], 0);
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        chk({tag, " rst valid"}, vld[s], 0);
        chk({tag, " rst data"}, dat[s], 0);
        chk({tag, " rst req"}, req[s], 0);
        tick();
        tick();
        reset = 1'b0;
        return;
      end
      if (i == drop_at) begin
        div[s] = 1'b1;
        data_in = 32'hFFFF_FFFF;
      end
      tick();
    end
    chk({tag, " end valid"}, vld[s], 0);
    chk({tag, " end data"}, dat[s], 0);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    int cnt;
    reset = 1'b1;
    div = '0;
    ack = 1'b0;
    data_in = '0;
    tick();
    tick();
    chk("rst ready", rdy[0], 1);
    chk("rst req", req[0], 0);
    chk("rst valid", vld[0], 0);
    chk("rst data", dat[0], 0);
    chk("rst len", len[0], 8);
    chk("rst drop", drp[0], 0);
    chk("rst tout", tout[0], 0);
    reset = 1'b0;
    tick();
    chk("post rst ready", rdy[0], 1);
    send(0, 32'h1234_5678, 16'h0000, 3, -1, -1, "t1");
    wait_ready(0, k);
    chk("t1 gap", k + 1, 9);
    pulse_reset();
    send(0, 32'hDEAD_BEEF, 16'h0000, 1, -1, -1, "t2a");
    wait_ready(0, k);
    chk("t2 gap", k + 1, 9);
    send(0, 32'hCAFE_F00D, 16'h0001, 2, -1, -1, "t2b");
    wait_ready(0, k);
    send(0, 32'h0BAD_F00D, 16'h0002, 1, 3, -1, "t3");
    wait_ready(0, k);
    pulse_reset();
    data_in = 32'h1111_1111;
    div[0] = 1'b1;
    tick();
    div[0] = 1'b0;
    cnt = 1;
    chk("t4 req", req[0], 1);
    while (req[0] && cnt < 2000) begin
      tick();
      if (req[0]) cnt++;
    end
    chk("t4 req cycles", cnt, 1024);
    chk("t4 tout pulse", tout[0], 1);
    chk("t4 idle", rdy[0], 1);
    tick();
    chk("t4 tout end", tout[0], 0);
    send(0, 32'h2222_2222, 16'h0000, 1, -1, -1, "t4b");
    send(1, 32'hA1B2_C3D4, 16'hFFFF, 1, -1, -1, "t5a");
    wait_ready(1, k);
    send(1, 32'h0102_0304, 16'h0000, 2, -1, -1, "t5b");
    wait_ready(0, k);
    send(0, 32'h5566_7788, 16'h0001, 1, -1, 4, "t6");
    tick();
    chk("t6 ready", rdy[0], 1);
    chk("t6 req", req[0], 0);
    send(0, 32'h99AA_BBCC, 16'h0000, 1, -1, -1, "t6b");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
